// File: rtl/add32_byte_serial_ctrl_pkg.sv
// Shared definitions for the byte-serial adder: FSM states, the slice width,
// and the helper that sets how many slice passes one add takes.
package add32_byte_serial_ctrl_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add32_byte_serial_ctrl_adder_8.sv
// 8-bit ripple-carry slice, reused once per byte by the serial controller.
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic carry;

  // The carry is a running variable so the chain is evaluated in bit order.
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/add32_byte_serial_ctrl.sv
// WIDTH-bit adder built from one 8-bit slice used for WIDTH/8 consecutive
// cycles, with valid/ready handshakes on the operand and result sides.
module add32_byte_serial_ctrl
  import add32_byte_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int NUM_SLICES = num_slices(WIDTH);
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_SLICES - 1);

  generate
    if (WIDTH <= 0 || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("add32_byte_serial_ctrl: WIDTH must be a nonzero multiple of 8");
    end
  endgenerate

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; the sender holds its payload until then, and ready never
  // depends combinationally on valid.

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_cin, slice_cout;

  assign slice_a   = a_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign slice_b   = b_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign slice_cin = (k_q == '0) ? cin_q : carry_q;

  adder_8 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          cin_d   = cin;
          acc_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          carry_d = 1'b0;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[int'(k_q)*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_cout;
        k_d     = k_q + KW'(1);
        // Partial bytes stay in acc; the visible result updates only once, here.
        if (k_q == K_LAST) begin
          k_d     = '0;
          sum_d   = acc_d;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_add32_byte_serial_ctrl.sv
// Directed and random checks of the byte-serial adder against a plain
// arithmetic reference: {cout,sum} = in1 + in2 + cin.
module tb_add32_byte_serial_ctrl;

  localparam int W  = 32;
  localparam int NS = W / 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1, in2;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];

  add32_byte_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {v, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
    in1 = a; in2 = b; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; cin = 1'($urandom_range(0, 1));
    exp_q.push_back(model(a, b, c));
  endtask

  task automatic wait_result();
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("run_in_ready", {63'd0, in_ready}, 64'd0);
      check("run_busy", {63'd0, busy}, 64'd1);
      in_valid = 1'($urandom_range(0, 1));
      in1 = $urandom; in2 = $urandom;
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    check("latency", 64'(lat), 64'(NS));
  endtask

  task automatic drain(input int stall);
    logic [W+1:0] exp_v;
    exp_v = exp_q.pop_front();
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("hold_data", 64'({ovf, cout, sum}), 64'(exp_v));
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
    end
    check("result", 64'({ovf, cout, sum}), 64'(exp_v));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_drop", {63'd0, out_valid}, 64'd0);
    check("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      check("idle_in_ready", {63'd0, in_ready}, 64'd1);
      check("idle_out_valid", {63'd0, out_valid}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
      check("idle_outputs", 64'({ovf, cout, sum}), 64'd0);
      tick();
    end

    // Basic add with carry crossing the byte boundary
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_result();
    check("basic_sum", 64'(sum), 64'h0000_0100);
    drain(0);

    // Full ripple and signed overflow
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_result();
    check("ripple_cout", {63'd0, cout}, 64'd1);
    drain(0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_result();
    check("ovf_flag", {63'd0, ovf}, 64'd1);
    drain(0);

    // Backpressure for 7 cycles
    send(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    wait_result();
    drain(7);

    // Reset after two slices completed
    send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    check("run_sum_cleared", 64'(sum), 64'd0);
    tick(); tick();
    check("mid_run_sum_stable", 64'({ovf, cout, sum}), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(exp_q.pop_back());
    for (int i = 0; i < 8; i++) begin
      check("abort_no_valid", {63'd0, out_valid}, 64'd0);
      check("abort_outputs", 64'({ovf, cout, sum}), 64'd0);
      check("abort_idle", {63'd0, in_ready}, 64'd1);
      tick();
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_result();
    check("after_abort_sum", 64'(sum), 64'h2345_6789);
    drain(1);

    // Random regression with random stalls
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_result();
      drain($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add32_byte_serial_ctrl.md
Name: add32_byte_serial_ctrl

Overview:
- Sequencer that performs a WIDTH-bit add, default 32, by reusing one 8-bit ripple slice (adder_8) for WIDTH/8 consecutive cycles.
- Carries between slices are held in a register.
- Trades latency for area; sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Intended as the low-area alternative to the flat 32-bit adder in datapaths that do not need single-cycle results.

Parameters:
- WIDTH, 32: operand and result width. Must be a nonzero multiple of 8; anything else is an elaboration error.
- NUM_SLICES, WIDTH/8: derived, not overridden. Number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  addend A.
- in2  input  WIDTH  addend B.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  A+B+cin, low WIDTH bits.
- cout  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow: A[MSB]==B[MSB] and sum[MSB]!=A[MSB].
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; slice index, carry register, operand registers and result register are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Reset asserted mid-RUN or mid-DONE aborts the operation; the partial result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in1, in2 and cin into registers; clear the result register; set slice index k=0; go to RUN.
  - in_valid=0 keeps the block in IDLE with all registers unchanged.
- RUN:
  - in_ready=0.
  - The slice sees A[8k+7:8k], B[8k+7:8k] and carry-in. The carry-in is the captured cin when k=0, otherwise the carry register.
  - Each edge writes the slice sum into result byte k, loads the slice cout into the carry register, and increments k.
  - On the edge where k=NUM_SLICES-1: write the last byte, register cout, compute ovf from the captured operand MSBs and the final sum MSB, and go to DONE.
  - Input-side activity during RUN is ignored; operand registers are stable.
- DONE:
  - out_valid=1. sum, cout and ovf are stable and held until the handshake completes.
  - Edge with out_ready=1: go to IDLE and drop out_valid.
  - out_ready=0: stay in DONE indefinitely (backpressure).
  - in_ready=0 in DONE; no same-cycle accept of new operands.
- Timing:
  - Latency: out_valid rises NUM_SLICES edges after the accept edge (4 for WIDTH=32).
  - Minimum issue interval is NUM_SLICES+2 cycles.
- Output stability:
  - sum, cout and ovf change only on the final RUN edge, on reset, or on the IDLE accept edge (cleared).
  - The consumer must sample them only while out_valid=1.
- Arithmetic:
  - The result is modulo 2^WIDTH; cout is the true carry-out.
  - all-ones + 0 + cin=1 gives sum=0, cout=1.
- Simultaneous events: rst dominates in_valid and out_ready in every state.

Decomposition:
- Shared adder package:
  - FSM state enumeration (IDLE/RUN/DONE).
  - Constant SLICE_W=8.
  - Function deriving NUM_SLICES from WIDTH.
- Sub-module: the existing adder_8, instantiated exactly once as the shared slice. No other sub-modules.
- Slice-operand selection is a mux on k inside this block.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, sum=0, cout=0, busy=0 held for 10 cycles with in_valid=0.
- Basic add: in1=0x0000_00FF, in2=0x0000_0001, cin=0, accepted at cycle T, out_ready=1 -> out_valid at T+4 with sum=0x0000_0100, cout=0, ovf=0; byte-0 carry propagates across the slice boundary.
- Full ripple: in1=0xFFFF_FFFF, in2=0, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. Then in1=0x7FFF_FFFF, in2=1, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 7 cycles after out_valid -> sum/cout/ovf unchanged, in_ready=0 throughout. out_ready=1 -> IDLE next edge; new operands accepted only once in_ready=1.
- Reset mid-RUN: assert rst on the edge after two slices have completed -> out_valid never rises for that operation, outputs zero. A following add of 0x1234_5678+0x1111_1111 gives 0x2345_6789, unaffected.
- Random regression: 1000 random in1/in2/cin with random out_ready stalls -> every result matches the reference {cout,sum}=in1+in2+cin, with no duplicated and no dropped transactions.
